// File: rtl/tmds_decoder.sv
// TMDS channel decoder: finds word alignment in a two-word history window by
// hunting for control-token runs, tracks lock with a timeout, and decodes data.
module tmds_decoder #(
  parameter int LOCK_RUN = 8,
  parameter int TIMEOUT  = 4095
) (
  input  logic       i_hdmi_clk,
  input  logic       i_reset_n,
  input  logic [9:0] i_tmds,
  output logic [7:0] o_data,
  output logic [1:0] o_ctrl,
  output logic       o_de,
  output logic       o_locked,
  output logic [3:0] o_offset
);

  localparam int RUN_W = $clog2(LOCK_RUN + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LOCK_RUN);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [19:0]      h_r;
  logic [RUN_W-1:0] run_r;
  logic [RUN_W-1:0] run_next_s;
  logic [TMO_W-1:0] tmo_r;
  logic [TMO_W-1:0] tmo_next_s;
  logic [3:0]       offset_r;
  logic [3:0]       offset_next_s;
  logic [9:0]       cand_s;
  logic             tok_s;
  logic [1:0]       tok_ctrl_s;
  logic [7:0]       dec_s;
  logic [7:0]       data_r;
  logic [7:0]       data_next_s;
  logic [1:0]       ctrl_r;
  logic [1:0]       ctrl_next_s;
  logic             de_r;
  logic             de_next_s;

  // Transition-minimised word back to the original byte.
  function automatic logic [7:0] tmds_decode(input logic [9:0] q);
    logic [7:0] b;
    logic [7:0] d;
    b    = q[9] ? ~q[7:0] : q[7:0];
    d    = 8'h00;
    d[0] = b[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (b[i] ^ b[i-1]) : ~(b[i] ^ b[i-1]);
    end
    return d;
  endfunction

  // Candidate word selection from the history window at the current offset.
  always_comb begin
    cand_s = h_r[9:0];
    case (offset_r)
      4'd0:    cand_s = h_r[9:0];
      4'd1:    cand_s = h_r[10:1];
      4'd2:    cand_s = h_r[11:2];
      4'd3:    cand_s = h_r[12:3];
      4'd4:    cand_s = h_r[13:4];
      4'd5:    cand_s = h_r[14:5];
      4'd6:    cand_s = h_r[15:6];
      4'd7:    cand_s = h_r[16:7];
      4'd8:    cand_s = h_r[17:8];
      4'd9:    cand_s = h_r[18:9];
      default: cand_s = h_r[9:0];
    endcase
  end

  // Control-token classification and data decode of the candidate.
  always_comb begin
    tok_s      = 1'b1;
    tok_ctrl_s = 2'b00;
    case (cand_s)
      10'h354: tok_ctrl_s = 2'b00;
      10'h0AB: tok_ctrl_s = 2'b01;
      10'h154: tok_ctrl_s = 2'b10;
      10'h2AB: tok_ctrl_s = 2'b11;
      default: tok_s = 1'b0;
    endcase
    dec_s = tmds_decode(cand_s);
  end

  // Alignment FSM: hunt offsets until a token run, then watch for token loss.
  always_comb begin
    state_next_s  = state_r;
    run_next_s    = run_r;
    tmo_next_s    = tmo_r;
    offset_next_s = offset_r;
    case (state_r)
      SEARCH: begin
        if (tok_s) begin
          if (run_r != RUN_MAX) begin
            run_next_s = run_r + 1'b1;
          end else begin
            run_next_s = run_r;
          end
          if (run_next_s == RUN_MAX) begin
            state_next_s = LOCKED;
            tmo_next_s   = {TMO_W{1'b0}};
          end else begin
            state_next_s = SEARCH;
          end
        end else begin
          run_next_s    = {RUN_W{1'b0}};
          offset_next_s = (offset_r == 4'd9) ? 4'd0 : offset_r + 4'd1;
        end
      end
      LOCKED: begin
        // A token always wins over an expiring timeout.
        if (tok_s) begin
          tmo_next_s = {TMO_W{1'b0}};
        end else if (tmo_r != TMO_MAX) begin
          tmo_next_s = tmo_r + 1'b1;
        end else begin
          tmo_next_s = tmo_r;
        end
        if (!tok_s && (tmo_next_s == TMO_MAX)) begin
          state_next_s = SEARCH;
          run_next_s   = {RUN_W{1'b0}};
          tmo_next_s   = {TMO_W{1'b0}};
        end else begin
          state_next_s = LOCKED;
        end
      end
      default: begin
        state_next_s = SEARCH;
      end
    endcase
  end

  // Output word selection, gated by the state being entered on this edge.
  always_comb begin
    data_next_s = 8'h00;
    ctrl_next_s = ctrl_r;
    de_next_s   = 1'b0;
    if (state_next_s == LOCKED) begin
      if (tok_s) begin
        ctrl_next_s = tok_ctrl_s;
      end else begin
        de_next_s   = 1'b1;
        data_next_s = dec_s;
      end
    end else begin
      ctrl_next_s = 2'b00;
    end
  end

  // State, history and output registers.
  always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r  <= SEARCH;
      h_r      <= 20'h00000;
      run_r    <= {RUN_W{1'b0}};
      tmo_r    <= {TMO_W{1'b0}};
      offset_r <= 4'd0;
      data_r   <= 8'h00;
      ctrl_r   <= 2'b00;
      de_r     <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      h_r      <= {i_tmds, h_r[19:10]};
      run_r    <= run_next_s;
      tmo_r    <= tmo_next_s;
      offset_r <= offset_next_s;
      data_r   <= data_next_s;
      ctrl_r   <= ctrl_next_s;
      de_r     <= de_next_s;
    end
  end

  assign o_data   = data_r;
  assign o_ctrl   = ctrl_r;
  assign o_de     = de_r;
  assign o_locked = (state_r == LOCKED);
  assign o_offset = offset_r;

endmodule
